ps2_tecla_decoder: RTL and testbench



---
 rtl/piano_pkg.sv | 64 ++++++
 rtl/ps2_rx_frame.sv | 126 ++++++++++++
 rtl/ps2_tecla_decoder.sv | 70 +++++++
 tb/tb_ps2_tecla_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared types and constants for the PS/2 piano keyboard path: key-code width,
// PS/2 prefix bytes, frame/decoder state encodings and the scan-code map.
package piano_pkg;

  localparam int TECLA_W = 6;
  localparam logic [TECLA_W-1:0] TECLA_NONE = '0;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    DEC_MAKE,
    DEC_BREAK,
    DEC_EXT,
    DEC_EXT_BREAK
  } dec_state_t;

  // Upper row (1..16) is the number row plus QWERTY; lower row (17..32) is ASDF plus ZXCV.
  function automatic logic [TECLA_W-1:0] scan_to_tecla(input logic [7:0] code);
    case (code)
      8'h16: return 6'd1;
      8'h1E: return 6'd2;
      8'h26: return 6'd3;
      8'h25: return 6'd4;
      8'h2E: return 6'd5;
      8'h36: return 6'd6;
      8'h3D: return 6'd7;
      8'h3E: return 6'd8;
      8'h46: return 6'd9;
      8'h45: return 6'd10;
      8'h15: return 6'd11;
      8'h1D: return 6'd12;
      8'h24: return 6'd13;
      8'h2D: return 6'd14;
      8'h2C: return 6'd15;
      8'h35: return 6'd16;
      8'h1C: return 6'd17;
      8'h1B: return 6'd18;
      8'h23: return 6'd19;
      8'h2B: return 6'd20;
      8'h34: return 6'd21;
      8'h33: return 6'd22;
      8'h3B: return 6'd23;
      8'h42: return 6'd24;
      8'h4B: return 6'd25;
      8'h1A: return 6'd26;
      8'h22: return 6'd27;
      8'h21: return 6'd28;
      8'h2A: return 6'd29;
      8'h32: return 6'd30;
      8'h31: return 6'd31;
      8'h3A: return 6'd32;
      default: return TECLA_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizers, ps2_clk deglitch filter, falling-edge detect,
// 11-bit frame FSM with inactivity timeout. Odd parity is enforced only with PS2_PARITY_CHK_EN.
module ps2_rx_frame
  import piano_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          parity_ok;

  // NOTE: synchronizers and filter reset to 1 (the idle bus level) so leaving
  // reset never looks like a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      fall      <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere in clocked logic so every register sees
      // the pre-edge value of its neighbours, like real flops.
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= 1'b0;
      if (clk_sync[1] != clk_filt) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_filt <= clk_sync[1];
          filt_cnt <= '0;
          fall     <= clk_filt;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

`ifdef PS2_PARITY_CHK_EN
  logic parity_bit;
  assign parity_ok = ^{shreg, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FR_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          FR_IDLE: begin
            bit_cnt <= '0;
            if (data_sync[1]) frame_err <= 1'b1;
            else              state     <= FR_DATA;
          end
          FR_DATA: begin
            shreg   <= {data_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= FR_PARITY;
          end
          FR_PARITY: begin
`ifdef PS2_PARITY_CHK_EN
            parity_bit <= data_sync[1];
`endif
            state <= FR_STOP;
          end
          FR_STOP: begin
            if (data_sync[1] && parity_ok) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= FR_IDLE;
          end
          default: state <= FR_IDLE;
        endcase
      end else if (state != FR_IDLE) begin
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          state     <= FR_IDLE;
          frame_err <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_tecla_decoder.sv
// PS/2 set-2 keyboard to piano key code: make/break/extended decoding on top of
// ps2_rx_frame. Build with PS2_PARITY_CHK_EN to drop frames with bad odd parity.
module ps2_tecla_decoder
  import piano_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic [TECLA_W-1:0] tecla,
  output logic               key_event,
  output logic               frame_err
);

  logic               byte_valid;
  logic [7:0]         byte_data;
  logic [TECLA_W-1:0] code;
  dec_state_t         dstate;

  ps2_rx_frame #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign code = scan_to_tecla(byte_data);

  always_ff @(posedge clock) begin
    if (reset) begin
      dstate    <= DEC_MAKE;
      tecla     <= TECLA_NONE;
      key_event <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (byte_valid) begin
        case (dstate)
          DEC_MAKE: begin
            if (byte_data == PS2_BREAK)    dstate <= DEC_BREAK;
            else if (byte_data == PS2_EXT) dstate <= DEC_EXT;
            else if (code != TECLA_NONE && code != tecla) begin
              tecla     <= code;
              key_event <= 1'b1;
            end
          end
          DEC_BREAK: begin
            // Releasing a key other than the one shown leaves the display alone.
            if (code != TECLA_NONE && code == tecla) begin
              tecla     <= TECLA_NONE;
              key_event <= 1'b1;
            end
            dstate <= DEC_MAKE;
          end
          DEC_EXT: dstate <= (byte_data == PS2_BREAK) ? DEC_EXT_BREAK : DEC_MAKE;
          default: dstate <= DEC_MAKE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_tecla_decoder.sv
// Scoreboard bench for ps2_tecla_decoder: randomized key sequences against a
// sequence-level reference model, plus error, timeout, glitch and reset cases.
module tb_ps2_tecla_decoder;

  typedef enum int {SQ_MAKE, SQ_BREAK, SQ_EXT, SQ_EXT_BREAK} seq_t;
  typedef struct {
    bit is_err;
    int tcode;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [5:0] tecla;
  logic       key_event;
  logic       frame_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   m_tecla = 0;

  logic [7:0] scan_tab [32] = '{
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
    8'h46, 8'h45, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
    8'h4B, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A};

  ps2_tecla_decoder #(.FILTER_LEN(8), .TIMEOUT(50000)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .tecla    (tecla),
    .key_event(key_event),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic int ref_map(input logic [7:0] c);
    for (int i = 0; i < 32; i++)
      if (scan_tab[i] == c) return i + 1;
    return 0;
  endfunction

  // Sequence-level model: a completed make/break either changes the shown key or not.
  task automatic model_apply(input seq_t kind, input logic [7:0] c);
    int k;
    k = ref_map(c);
    if (kind == SQ_MAKE && k != 0 && k != m_tecla) begin
      m_tecla = k;
      exp_q.push_back('{is_err: 1'b0, tcode: k});
    end else if (kind == SQ_BREAK && k != 0 && k == m_tecla) begin
      m_tecla = 0;
      exp_q.push_back('{is_err: 1'b0, tcode: 0});
    end
  endtask

  task automatic push_err();
    exp_q.push_back('{is_err: 1'b1, tcode: 0});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit gl);
    wait_cyc(8);
    ps2_data = b;
    if (!gl) begin
      wait_cyc(8);
      ps2_clk = 1'b0;
      wait_cyc(16);
      ps2_clk = 1'b1;
    end else begin
      wait_cyc(2);  ps2_clk = 1'b0;
      wait_cyc(4);  ps2_clk = 1'b1;
      wait_cyc(2);  ps2_clk = 1'b0;
      wait_cyc(11); ps2_clk = 1'b1;
      wait_cyc(3);  ps2_clk = 1'b0;
      wait_cyc(2);  ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit gl);
    ps2_bit(1'b0, gl);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], gl);
    ps2_bit((~^b) ^ bad_par, gl);
    ps2_bit(~bad_stop, gl);
    wait_cyc(8);
    ps2_data = 1'b1;
    wait_cyc(24);
  endtask

  task automatic send_seq(input seq_t kind, input logic [7:0] c);
    model_apply(kind, c);
    if (kind == SQ_EXT || kind == SQ_EXT_BREAK) send_frame(8'hE0, 0, 0, 0);
    if (kind == SQ_BREAK || kind == SQ_EXT_BREAK) send_frame(8'hF0, 0, 0, 0);
    send_frame(c, 0, 0, 0);
  endtask

  task automatic expect_tecla(input string name);
    @(negedge clock);
    check(name, int'(tecla), m_tecla);
  endtask

  task automatic observe(input bit kind);
    exp_t e;
    check("event_pending", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("event_kind", int'(kind), int'(e.is_err));
      if (!kind && !e.is_err) check("key_event_tecla", int'(tecla), e.tcode);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (key_event) observe(1'b0);
        if (frame_err) observe(1'b1);
      end
    end
  end

  initial begin
    logic [7:0] c;
    int         r;

    wait_cyc(5);
    @(negedge clock);
    check("reset_tecla", int'(tecla), 0);
    check("reset_key_event", int'(key_event), 0);
    check("reset_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    wait_cyc(20);

    send_seq(SQ_MAKE, 8'h16);      expect_tecla("t1_make_16");
    send_seq(SQ_BREAK, 8'h16);     expect_tecla("t1_break_16");

    send_seq(SQ_MAKE, 8'h1C);      expect_tecla("t2_make_1c");
    send_seq(SQ_MAKE, 8'h3A);      expect_tecla("t2_make_3a");
    send_seq(SQ_BREAK, 8'h1C);     expect_tecla("t2_break_other");

    send_seq(SQ_EXT, 8'h75);       expect_tecla("t3_ext_make");
    send_seq(SQ_EXT_BREAK, 8'h75); expect_tecla("t3_ext_break");
    send_seq(SQ_MAKE, 8'h76);      expect_tecla("t3_unmapped");
    send_seq(SQ_BREAK, 8'h3A);     expect_tecla("t3_release");

`ifdef PS2_PARITY_CHK_EN
    push_err();
`else
    model_apply(SQ_MAKE, 8'h16);
`endif
    send_frame(8'h16, 1, 0, 0);    expect_tecla("t4_bad_parity");

    push_err();
    ps2_bit(1'b1, 0);
    wait_cyc(24);                  expect_tecla("bad_start");
    push_err();
    send_frame(8'h2C, 0, 1, 0);    expect_tecla("bad_stop");

    push_err();
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'(i & 1), 0);
    ps2_data = 1'b1;
    wait_cyc(50200);               expect_tecla("t5_timeout");
    send_seq(SQ_MAKE, 8'h45);      expect_tecla("t5_after_timeout");

    for (int n = 0; n < 20; n++) begin
      r = $urandom_range(0, 5);
      c = scan_tab[$urandom_range(0, 31)];
      case (r)
        0, 1: send_seq(SQ_MAKE, c);
        2:    send_seq(SQ_BREAK, (m_tecla != 0) ? scan_tab[m_tecla - 1] : c);
        3:    send_seq(SQ_BREAK, c);
        4: begin
          c = 8'($urandom_range(0, 255));
          if (c == 8'hF0) c = 8'h75;
          send_seq(($urandom_range(0, 1) != 0) ? SQ_EXT : SQ_EXT_BREAK, c);
        end
        default: begin
          if (m_tecla != 0 && $urandom_range(0, 1) != 0) begin
            send_seq(SQ_MAKE, scan_tab[m_tecla - 1]);
          end else begin
            do c = 8'($urandom_range(0, 255));
            while (ref_map(c) != 0 || c == 8'hF0 || c == 8'hE0);
            send_seq(SQ_MAKE, c);
          end
        end
      endcase
      expect_tecla("random_seq");
    end

    model_apply(SQ_MAKE, 8'h35);
    send_frame(8'h35, 0, 0, 1);    expect_tecla("t6_glitch_35");

    for (int i = 0; i < 4; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1, 0);
    reset = 1'b1;
    wait_cyc(1);
    @(negedge clock);
    check("t6_reset_tecla", int'(tecla), 0);
    check("t6_reset_key_event", int'(key_event), 0);
    m_tecla = 0;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(20);
    send_seq(SQ_MAKE, 8'h16);      expect_tecla("t6_after_reset");

    wait_cyc(50);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
